rob_ctrl: RTL

ROB_CTRL -- requirements
Module: rob_ctrl

---
 rtl/rob_pkg.sv | 25 ++
 rtl/rob_ptr_cmp.sv | 21 ++
 rtl/rob_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder-buffer controller (rob_ctrl).
package rob_pkg;

  localparam int ROB_ENTRIES = 128;
  localparam int ROB_PTR_W   = $clog2(ROB_ENTRIES);

  typedef enum logic [2:0] {
    READY     = 3'd0,
    ISSUED    = 3'd1,
    DONE      = 3'd2,
    EXCEPTION = 3'd3,
    INTERRUPT = 3'd4,
    TRAP      = 3'd5
  } status_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rob_ctrl_state_t;

  function automatic logic is_fault(status_t s);
    return (s == EXCEPTION) || (s == INTERRUPT) || (s == TRAP);
  endfunction

endpackage

// File: rtl/rob_ptr_cmp.sv
// Age of an index relative to head and whether it lies in [head, tail) with wrap.
module rob_ptr_cmp
  import rob_pkg::*;
#(
  parameter int PTR_W = ROB_PTR_W
) (
  input  logic [PTR_W:0]   head_ptr,
  input  logic [PTR_W:0]   tail_ptr,
  input  logic [PTR_W-1:0] idx,
  output logic [PTR_W-1:0] age,
  output logic             in_range
);

  logic [PTR_W:0] occupancy;

  // Modular distance from head; anything closer than the occupancy is live.
  assign occupancy = tail_ptr - head_ptr;
  assign age       = idx - head_ptr[PTR_W-1:0];
  assign in_range  = ({1'b0, age} < occupancy);

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: in-order allocate/retire, out-of-order completion,
// fault flush and mispredict squash. Define ROB_PERF_CNT_EN for perf counters.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int ROB_ENTRIES = rob_pkg::ROB_ENTRIES
) (
  input  logic                           clk_in,
  input  logic                           rst_N_in,
  input  logic                           alloc_valid_in,
  output logic                           alloc_ready_out,
  output logic [$clog2(ROB_ENTRIES)-1:0] alloc_ptr_out,
  input  logic                           complete_valid_in,
  input  logic [$clog2(ROB_ENTRIES)-1:0] complete_ptr_in,
  input  status_t                        complete_status_in,
  output logic                           retire_valid_out,
  output logic [$clog2(ROB_ENTRIES)-1:0] retire_ptr_out,
  input  logic                           retire_ready_in,
  input  logic                           mispredict_valid_in,
  input  logic [$clog2(ROB_ENTRIES)-1:0] mispredict_ptr_in,
  output logic                           flush_out,
  output logic [$clog2(ROB_ENTRIES)-1:0] flush_ptr_out,
  output status_t                        flush_cause_out,
  output logic [$clog2(ROB_ENTRIES):0]   count_out,
  output logic                           empty_out,
`ifdef ROB_PERF_CNT_EN
  output logic [31:0]                    perf_full_stall_out,
  output logic [31:0]                    perf_flush_out,
`endif
  output logic                           full_out
);

  localparam int IW = $clog2(ROB_ENTRIES);
  localparam logic [IW:0] PTR_ONE = (IW+1)'(1);
  localparam logic [IW:0] FULL_COUNT = (IW+1)'(ROB_ENTRIES);

  rob_ctrl_state_t state_q;
  logic [IW:0]     head_q;
  logic [IW:0]     tail_q;
  status_t         status_q [ROB_ENTRIES];

  logic [IW:0]     count;
  status_t         head_status;
  logic            head_fault;
  logic [IW-1:0]   c_age;
  logic            c_in_range;
  logic [IW-1:0]   m_age;
  logic            m_in_range;
  logic            do_alloc;
  logic            do_retire;
  logic            do_mp;
  logic            do_complete;
  logic            start_flush;
  logic [ROB_ENTRIES-1:0] squash;
  logic [IW-1:0]   entry_age;

  assign count       = tail_q - head_q;
  assign count_out   = count;
  assign empty_out   = (count == '0);
  assign full_out    = (count == FULL_COUNT);
  assign head_status = status_q[head_q[IW-1:0]];
  assign head_fault  = is_fault(head_status);

  assign alloc_ready_out  = !full_out && (state_q == RUN) && !mispredict_valid_in;
  assign alloc_ptr_out    = tail_q[IW-1:0];
  assign retire_valid_out = (state_q == RUN) && !empty_out && (head_status == DONE);
  assign retire_ptr_out   = head_q[IW-1:0];

  rob_ptr_cmp #(.PTR_W(IW)) u_cmp_complete (
    .head_ptr (head_q),
    .tail_ptr (tail_q),
    .idx      (complete_ptr_in),
    .age      (c_age),
    .in_range (c_in_range)
  );

  rob_ptr_cmp #(.PTR_W(IW)) u_cmp_mispredict (
    .head_ptr (head_q),
    .tail_ptr (tail_q),
    .idx      (mispredict_ptr_in),
    .age      (m_age),
    .in_range (m_in_range)
  );

  assign do_alloc    = alloc_valid_in && alloc_ready_out;
  assign do_retire   = retire_valid_out && retire_ready_in;
  assign do_mp       = (state_q == RUN) && mispredict_valid_in && m_in_range;
  assign start_flush = (state_q == RUN) && !empty_out && head_fault;
  // A completion younger than a same-cycle mispredict belongs to a squashed entry.
  assign do_complete = (state_q == RUN) && complete_valid_in && c_in_range &&
                       (status_q[complete_ptr_in] == ISSUED) &&
                       !(do_mp && (c_age > m_age));

  always_comb begin
    squash    = '0;
    entry_age = '0;
    for (int i = 0; i < ROB_ENTRIES; i++) begin
      entry_age = IW'(i) - head_q[IW-1:0];
      squash[i] = (entry_age > m_age) && ({1'b0, entry_age} < count);
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q         <= RUN;
      head_q          <= '0;
      tail_q          <= '0;
      flush_out       <= 1'b0;
      flush_ptr_out   <= '0;
      flush_cause_out <= READY;
      for (int i = 0; i < ROB_ENTRIES; i++) status_q[i] <= READY;
    end else begin
      flush_out <= 1'b0;
      case (state_q)
        RUN: begin
          if (start_flush) begin
            state_q         <= FLUSH;
            flush_out       <= 1'b1;
            flush_ptr_out   <= head_q[IW-1:0];
            flush_cause_out <= head_status;
          end
          if (do_retire) begin
            status_q[head_q[IW-1:0]] <= READY;
            head_q                   <= head_q + PTR_ONE;
          end
          if (do_complete) status_q[complete_ptr_in] <= complete_status_in;
          // Mispredict rebuilds tail from head so the wrap bit stays consistent.
          if (do_mp) begin
            tail_q <= head_q + {1'b0, m_age} + PTR_ONE;
            for (int i = 0; i < ROB_ENTRIES; i++)
              if (squash[i]) status_q[i] <= READY;
          end else if (do_alloc) begin
            status_q[tail_q[IW-1:0]] <= ISSUED;
            tail_q                   <= tail_q + PTR_ONE;
          end
        end
        FLUSH: begin
          for (int i = 0; i < ROB_ENTRIES; i++) status_q[i] <= READY;
          tail_q  <= head_q;
          state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      perf_full_stall_out <= '0;
      perf_flush_out      <= '0;
    end else begin
      if (alloc_valid_in && full_out && (perf_full_stall_out != '1))
        perf_full_stall_out <= perf_full_stall_out + 32'd1;
      if (start_flush && (perf_flush_out != '1))
        perf_flush_out <= perf_flush_out + 32'd1;
    end
  end
`endif

endmodule
